// File: rtl/bus_loader_pkg.sv
// Shared constants and state encoding for the byte-stream bus initiator.
// Frame opcodes, response bytes and the loader FSM states.
package bus_loader_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN,
    S_WDATA,
    S_WRITE,
    S_READ,
    S_RCAP,
    S_SEND,
    S_ACK,
    S_NAK
  } state_t;

endpackage

// File: rtl/bus_loader.sv
// Byte-stream bus initiator: parses serial command frames and runs
// burst reads/writes on the data/IO bus under a request/grant handshake.
module bus_loader
  import bus_loader_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [15:0] address,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        w_en,
  output logic        r_en
);

  localparam int TW = $clog2(int'(TIMEOUT_CYCLES) + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 16'd1);

  state_t        state, state_n;
  logic          is_wr, is_wr_n;
  logic [7:0]    count, count_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [15:0]   address_n;
  logic [7:0]    bus_dout_n;
  logic [7:0]    tx_data_n;
  logic          tx_valid_n;
  logic          bus_req_n;
  logic          w_en_n;
  logic          r_en_n;
  logic          tmo_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      is_wr    <= 1'b0;
      count    <= '0;
      tmo      <= '0;
      address  <= '0;
      bus_dout <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      bus_req  <= 1'b0;
      w_en     <= 1'b0;
      r_en     <= 1'b0;
    end else begin
      state    <= state_n;
      is_wr    <= is_wr_n;
      count    <= count_n;
      tmo      <= tmo_n;
      address  <= address_n;
      bus_dout <= bus_dout_n;
      tx_data  <= tx_data_n;
      tx_valid <= tx_valid_n;
      bus_req  <= bus_req_n;
      w_en     <= w_en_n;
      r_en     <= r_en_n;
    end
  end

  assign tmo_state = (state == S_ADDR_HI) || (state == S_ADDR_LO) ||
                     (state == S_LEN) || (state == S_WDATA);

  always_comb begin
    state_n    = state;
    is_wr_n    = is_wr;
    count_n    = count;
    address_n  = address;
    bus_dout_n = bus_dout;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    bus_req_n  = bus_req;
    w_en_n     = 1'b0;
    r_en_n     = 1'b0;
    tmo_n      = '0;

    if (tmo_state && !rx_valid) begin
      tmo_n = tmo + TW'(1);
    end

    unique case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_WRITE) begin
            is_wr_n = 1'b1;
            state_n = S_ADDR_HI;
          end else if (rx_data == OP_READ) begin
            is_wr_n = 1'b0;
            state_n = S_ADDR_HI;
          end else begin
            state_n    = S_NAK;
            tx_valid_n = 1'b1;
            tx_data_n  = RSP_NAK;
          end
        end
      end
      S_ADDR_HI: begin
        if (rx_valid) begin
          address_n[15:8] = rx_data;
          state_n         = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (rx_valid) begin
          address_n[7:0] = rx_data;
          state_n        = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          count_n   = rx_data;
          bus_req_n = 1'b1;
          state_n   = is_wr ? S_WDATA : S_READ;
        end
      end
      S_WDATA: begin
        if (rx_valid) begin
          bus_dout_n = rx_data;
          w_en_n     = bus_grant;
          state_n    = S_WRITE;
        end
      end
      // w_en high here means this byte's strobe is already on the bus.
      S_WRITE: begin
        if (rx_valid) begin
          state_n    = S_NAK;
          bus_req_n  = 1'b0;
          tx_valid_n = 1'b1;
          tx_data_n  = RSP_NAK;
        end else if (w_en) begin
          address_n = address + 16'd1;
          if (count == 8'd0) begin
            state_n    = S_ACK;
            bus_req_n  = 1'b0;
            tx_valid_n = 1'b1;
            tx_data_n  = RSP_ACK;
          end else begin
            count_n = count - 8'd1;
            state_n = S_WDATA;
          end
        end else if (bus_grant) begin
          w_en_n = 1'b1;
        end
      end
      S_READ: begin
        if (r_en) begin
          state_n = S_RCAP;
        end else if (bus_grant) begin
          r_en_n = 1'b1;
        end
      end
      S_RCAP: begin
        tx_data_n  = bus_din;
        tx_valid_n = 1'b1;
        state_n    = S_SEND;
      end
      S_SEND: begin
        if (rx_valid) begin
          state_n    = S_NAK;
          bus_req_n  = 1'b0;
          tx_valid_n = 1'b1;
          tx_data_n  = RSP_NAK;
        end else if (tx_ready) begin
          tx_valid_n = 1'b0;
          address_n  = address + 16'd1;
          if (count == 8'd0) begin
            state_n   = S_IDLE;
            bus_req_n = 1'b0;
          end else begin
            count_n = count - 8'd1;
            state_n = S_READ;
          end
        end
      end
      S_ACK, S_NAK: begin
        if (tx_ready) begin
          tx_valid_n = 1'b0;
          state_n    = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (tmo_state && !rx_valid && tmo == TMO_LAST) begin
      state_n    = S_NAK;
      bus_req_n  = 1'b0;
      tx_valid_n = 1'b1;
      tx_data_n  = RSP_NAK;
      tmo_n      = '0;
    end
  end

endmodule

// File: tb/tb_bus_loader.sv
// Directed self-checking bench for bus_loader: writes, reads with
// address wrap, grant stall, bad opcode, timeout and mid-send reset.
module tb_bus_loader;

  localparam logic [15:0] TMO = 16'd200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        bus_req;
  logic        bus_grant = 1'b1;
  logic [15:0] address;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din = 8'h00;
  logic        w_en;
  logic        r_en;

  int n_checks = 0;
  int n_fail = 0;
  int viol = 0;

  int nw, nr, ntx;
  logic [15:0] w_addr [16];
  logic [7:0]  w_data [16];
  logic [15:0] r_addr [16];
  logic [7:0]  tx_log [16];

  bus_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_req(bus_req), .bus_grant(bus_grant),
    .address(address), .bus_dout(bus_dout), .bus_din(bus_din),
    .w_en(w_en), .r_en(r_en)
  );

  always #5 clk = ~clk;

  // Read-data model: one-cycle latency, data = low address byte ^ 0x50.
  always @(posedge clk) begin
    if (r_en) bus_din <= address[7:0] ^ 8'h50;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if ((w_en && r_en) || ((w_en || r_en) && !bus_grant)) viol++;
      if (w_en && nw < 16) begin
        w_addr[nw] = address;
        w_data[nw] = bus_dout;
      end
      if (w_en) nw++;
      if (r_en && nr < 16) r_addr[nr] = address;
      if (r_en) nr++;
      if (tx_valid && tx_ready && ntx < 16) tx_log[ntx] = tx_data;
      if (tx_valid && tx_ready) ntx++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    @(negedge clk);
    nw = 0;
    nr = 0;
    ntx = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int limit);
    for (int i = 0; i < limit && ntx < n; i++) @(negedge clk);
    check("tx_count", ntx, n);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_address", address, 16'h0000);
    check("rst_bus_dout", bus_dout, 8'h00);
    check("rst_strobes", {w_en, r_en}, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;

    // Burst write of three bytes, grant high.
    clear_logs();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    wait_tx(1, 50);
    check("wr_count", nw, 3);
    check("wr0", {w_addr[0], w_data[0]}, 24'h0010AA);
    check("wr1", {w_addr[1], w_data[1]}, 24'h0011BB);
    check("wr2", {w_addr[2], w_data[2]}, 24'h0012CC);
    check("wr_ack", tx_log[0], 8'h06);
    repeat (2) @(negedge clk);
    check("wr_req_low", bus_req, 1'b0);

    // Single read.
    clear_logs();
    send_byte(8'h52); send_byte(8'h10); send_byte(8'h0A); send_byte(8'h00);
    wait_tx(1, 50);
    check("rd_count", nr, 1);
    check("rd_addr", r_addr[0], 16'h100A);
    check("rd_data", tx_log[0], 8'h5A);
    repeat (2) @(negedge clk);
    check("rd_req_low", bus_req, 1'b0);

    // Two-byte read wrapping the address.
    clear_logs();
    send_byte(8'h52); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h01);
    wait_tx(2, 80);
    check("wrap_count", nr, 2);
    check("wrap_a0", r_addr[0], 16'hFFFF);
    check("wrap_a1", r_addr[1], 16'h0000);
    check("wrap_d0", tx_log[0], 8'hAF);
    check("wrap_d1", tx_log[1], 8'h50);

    // Grant withheld during a write for 100 cycles.
    clear_logs();
    bus_grant = 1'b0;
    send_byte(8'h57); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h11);
    repeat (100) @(negedge clk);
    check("stall_no_wen", nw, 0);
    check("stall_no_tx", ntx, 0);
    check("stall_req", bus_req, 1'b1);
    #1 bus_grant = 1'b1;
    wait_tx(1, 50);
    check("stall_wr", {w_addr[0], w_data[0]}, 24'h200011);
    check("stall_ack", tx_log[0], 8'h06);

    // Unknown opcode.
    clear_logs();
    send_byte(8'h41);
    wait_tx(1, 20);
    check("badop_nak", tx_log[0], 8'h15);
    check("badop_bus", nw + nr, 0);
    check("badop_req", bus_req, 1'b0);

    // Inter-byte timeout, then recovery with a good frame.
    clear_logs();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    repeat (150) @(negedge clk);
    check("tmo_early", ntx, 0);
    wait_tx(1, 150);
    check("tmo_nak", tx_log[0], 8'h15);
    check("tmo_bus", nw, 0);
    clear_logs();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
    wait_tx(1, 50);
    check("tmo_next", tx_log[0], 8'h55);

    // Reset while a read byte is waiting in SEND.
    clear_logs();
    tx_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
    check("send_valid", tx_valid, 1'b1);
    check("send_data", tx_data, 8'h51);
    repeat (5) @(negedge clk);
    check("send_hold", {tx_valid, tx_data}, 9'h151);
    check("send_req", bus_req, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check("rst_send_tx", tx_valid, 1'b0);
    check("rst_send_req", bus_req, 1'b0);
    rst = 1'b0;
    tx_ready = 1'b1;
    clear_logs();
    send_byte(8'h41);
    wait_tx(1, 20);
    check("rst_idle_nak", tx_log[0], 8'h15);

    check("bus_rules", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
